// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
// Capture sequencer between the ADC sample packer and the host-bound FIFO.
// Arms on a host start pulse, optionally waits for a level trigger, decimates
// the packed sample stream and pairs kept samples into 32-bit FIFO writes.
// Optional feature macro: ADC_CAPTURE_TRIG_EN adds the trig_level port and the
// rising-level trigger in ARM; without it ARM lasts exactly one cycle.
module adc_capture_ctrl #(
    parameter int CNT_W = 24,
    parameter int DEC_W = 8
) (
    input  logic             dco,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_words,
    input  logic [DEC_W-1:0] decim,
`ifdef ADC_CAPTURE_TRIG_EN
    input  logic [5:0]       trig_level,
`endif
    input  logic [15:0]      cat_data,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [31:0]      fifo_din,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] numWords_q, numWords_d;
    logic [DEC_W-1:0] decim_q, decim_d;
    logic [DEC_W-1:0] decCnt_q, decCnt_d;
    logic [CNT_W-1:0] wordCnt_q, wordCnt_d;
    logic [CNT_W-1:0] wordCntNext;
    logic [15:0]      lowHalf_q, lowHalf_d;
    logic             pairOdd_q, pairOdd_d;
    logic             fifoWrEn_q, fifoWrEn_d;
    logic [31:0]      fifoDin_q, fifoDin_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;
`ifdef ADC_CAPTURE_TRIG_EN
    logic [5:0]       prev_q, prev_d;
    logic             prevValid_q, prevValid_d;
`endif

    // State and datapath registers; reset clears everything, including the strobe.
    always_ff @(posedge dco or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            numWords_q  <= '0;
            decim_q     <= '0;
            decCnt_q    <= '0;
            wordCnt_q   <= '0;
            lowHalf_q   <= '0;
            pairOdd_q   <= 1'b0;
            fifoWrEn_q  <= 1'b0;
            fifoDin_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef ADC_CAPTURE_TRIG_EN
            prev_q      <= '0;
            prevValid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            numWords_q  <= numWords_d;
            decim_q     <= decim_d;
            decCnt_q    <= decCnt_d;
            wordCnt_q   <= wordCnt_d;
            lowHalf_q   <= lowHalf_d;
            pairOdd_q   <= pairOdd_d;
            fifoWrEn_q  <= fifoWrEn_d;
            fifoDin_q   <= fifoDin_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
`ifdef ADC_CAPTURE_TRIG_EN
            prev_q      <= prev_d;
            prevValid_q <= prevValid_d;
`endif
        end
    end

    // Next-state logic: sequencing, decimation, pairing and write attempts.
    // The strobe is a single-cycle pulse, so it defaults low every cycle.
    always_comb begin
        state_d     = state_q;
        numWords_d  = numWords_q;
        decim_d     = decim_q;
        decCnt_d    = decCnt_q;
        wordCnt_d   = wordCnt_q;
        wordCntNext = wordCnt_q + 1'b1;
        lowHalf_d   = lowHalf_q;
        pairOdd_d   = pairOdd_q;
        fifoWrEn_d  = 1'b0;
        fifoDin_d   = fifoDin_q;
        busy_d      = busy_q;
        done_d      = done_q;
        overflow_d  = overflow_q;
`ifdef ADC_CAPTURE_TRIG_EN
        prev_d      = prev_q;
        prevValid_d = prevValid_q;
`endif

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = ARM;
                    numWords_d = num_words;
                    decim_d    = decim;
                    done_d     = 1'b0;
                    overflow_d = 1'b0;
                    busy_d     = 1'b1;
`ifdef ADC_CAPTURE_TRIG_EN
                    prevValid_d = 1'b0;
`endif
                end
            end

            ARM: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
`ifdef ADC_CAPTURE_TRIG_EN
                    prev_d      = cat_data[15:10];
                    prevValid_d = 1'b1;
                    if (prevValid_q && (prev_q < trig_level) &&
                        (cat_data[15:10] >= trig_level)) begin
                        state_d   = CAPTURE;
                        decCnt_d  = '0;
                        wordCnt_d = '0;
                        pairOdd_d = 1'b0;
                    end
`else
                    state_d   = CAPTURE;
                    decCnt_d  = '0;
                    wordCnt_d = '0;
                    pairOdd_d = 1'b0;
`endif
                end
            end

            CAPTURE: begin
                if (abort) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    pairOdd_d = 1'b0;
                end else if (decCnt_q == '0) begin
                    decCnt_d = decim_q;
                    if (!pairOdd_q) begin
                        lowHalf_d = cat_data;
                        pairOdd_d = 1'b1;
                    end else begin
                        pairOdd_d = 1'b0;
                        wordCnt_d = wordCntNext;
                        if (fifo_full) begin
                            overflow_d = 1'b1;
                        end else begin
                            fifoWrEn_d = 1'b1;
                            fifoDin_d  = {cat_data, lowHalf_q};
                        end
                        if ((numWords_q != '0) && (wordCntNext == numWords_q)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end else begin
                    decCnt_d = decCnt_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign fifo_wr_en = fifoWrEn_q;
    assign fifo_din   = fifoDin_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Testbench for adc_capture_ctrl: behavioural model plus directed and random stimulus.
module tb_adc_capture_ctrl;

    logic        dco;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [23:0] num_words;
    logic [7:0]  decim;
`ifdef ADC_CAPTURE_TRIG_EN
    logic [5:0]  trig_level;
`endif
    logic [15:0] cat_data;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [31:0] fifo_din;
    logic        busy;
    logic        done;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int strobes = 0;

    // Behavioural model: phase 0 idle, 1 armed, 2 capturing.
    int          mPhase;
    int          mNumWords;
    int          mDecim;
    int          mCapCycles;
    int          mKept;
    logic [15:0] mLow;
    logic        mWrEn;
    logic [31:0] mDin;
    logic        mBusy;
    logic        mDone;
    logic        mOvf;
`ifdef ADC_CAPTURE_TRIG_EN
    int          mArmCycles;
    logic [5:0]  mPrev;
`endif

    adc_capture_ctrl #(.CNT_W(24), .DEC_W(8)) dut (
        .dco        (dco),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .num_words  (num_words),
        .decim      (decim),
`ifdef ADC_CAPTURE_TRIG_EN
        .trig_level (trig_level),
`endif
        .cat_data   (cat_data),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    initial dco = 1'b0;
    always #5 dco = ~dco;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: actual=%h expected=%h", name, cycle, act, exp);
        end
    endtask

    task automatic modelReset();
        mPhase = 0; mNumWords = 0; mDecim = 0; mCapCycles = 0; mKept = 0;
        mLow = '0; mWrEn = 1'b0; mDin = '0; mBusy = 1'b0; mDone = 1'b0; mOvf = 1'b0;
`ifdef ADC_CAPTURE_TRIG_EN
        mArmCycles = 0; mPrev = '0;
`endif
    endtask

    task automatic enterCapture();
        mPhase = 2; mCapCycles = 0; mKept = 0;
    endtask

    // One clock edge of the specification's rules, using the inputs present at the edge.
    task automatic modelStep();
        int words;
        logic [23:0] wc;
        mWrEn = 1'b0;
        case (mPhase)
            0: if (start && !abort) begin
                mPhase = 1; mNumWords = int'(num_words); mDecim = int'(decim);
                mDone = 1'b0; mOvf = 1'b0;
`ifdef ADC_CAPTURE_TRIG_EN
                mArmCycles = 0;
`endif
            end
            1: if (abort) mPhase = 0;
               else begin
`ifdef ADC_CAPTURE_TRIG_EN
                   if (mArmCycles > 0 && mPrev < trig_level && cat_data[15:10] >= trig_level)
                       enterCapture();
                   mPrev = cat_data[15:10];
                   mArmCycles++;
`else
                   enterCapture();
`endif
               end
            default: if (abort) mPhase = 0;
               else begin
                   if (mCapCycles % (mDecim + 1) == 0) begin
                       if (mKept % 2 == 0) mLow = cat_data;
                       else begin
                           words = (mKept + 1) / 2;
                           wc = words[23:0];
                           if (fifo_full) mOvf = 1'b1;
                           else begin
                               mWrEn = 1'b1;
                               mDin = {cat_data, mLow};
                           end
                           if (mNumWords != 0 && int'(wc) == mNumWords) begin
                               mPhase = 0; mDone = 1'b1;
                           end
                       end
                       mKept++;
                   end
                   mCapCycles++;
               end
        endcase
        mBusy = (mPhase != 0);
    endtask

    task automatic checkOutput();
        checkVal("wr_en", {31'd0, fifo_wr_en}, {31'd0, mWrEn});
        checkVal("busy", {31'd0, busy}, {31'd0, mBusy});
        checkVal("done", {31'd0, done}, {31'd0, mDone});
        checkVal("overflow", {31'd0, overflow}, {31'd0, mOvf});
        if (mWrEn) checkVal("din", fifo_din, mDin);
    endtask

    // Drive one cycle of inputs at the falling edge, then compare just after the rising edge.
    task automatic applyStimulus(input logic s, input logic a, input logic [23:0] nw,
                                 input logic [7:0] dec, input logic [15:0] data, input logic full);
        @(negedge dco);
        start = s; abort = a; num_words = nw; decim = dec; cat_data = data; fifo_full = full;
        @(posedge dco);
        cycle++;
        if (rst_n) modelStep(); else modelReset();
        #1;
        checkOutput();
        if (fifo_wr_en) strobes++;
    endtask

    task automatic checkAllZero(input string name);
        checkVal({name, "_wr_en"}, {31'd0, fifo_wr_en}, 32'd0);
        checkVal({name, "_din"}, fifo_din, 32'd0);
        checkVal({name, "_busy"}, {31'd0, busy}, 32'd0);
        checkVal({name, "_done"}, {31'd0, done}, 32'd0);
        checkVal({name, "_ovf"}, {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        int firstStrobe;
        int lastStrobe;
        logic [31:0] firstDin;
        logic [31:0] secondDin;
        start = 0; abort = 0; num_words = '0; decim = '0; cat_data = '0; fifo_full = 0;
`ifdef ADC_CAPTURE_TRIG_EN
        trig_level = 6'd32;
`endif
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAllZero("reset");
        repeat (2) @(posedge dco);
        @(negedge dco);
        rst_n = 1'b1;

`ifndef ADC_CAPTURE_TRIG_EN
        // Ramp with num_words=4, decim=0: first word {3,2}, strobes 2 cycles apart.
        strobes = 0; firstStrobe = -1; lastStrobe = -1; firstDin = '0;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(i == 0, 1'b0, 24'd4, 8'd0, 16'(i), 1'b0);
            if (fifo_wr_en) begin
                if (strobes == 1) begin firstStrobe = i; firstDin = fifo_din; end
                else checkVal("ramp_gap", 32'(i - lastStrobe), 32'd2);
                lastStrobe = i;
                if (strobes == 4) begin
                    checkVal("ramp_done_at4", {31'd0, done}, 32'd1);
                    checkVal("ramp_busy_at4", {31'd0, busy}, 32'd0);
                end
            end
        end
        checkVal("ramp_strobes", 32'(strobes), 32'd4);
        checkVal("ramp_first_cycle", 32'(firstStrobe), 32'd3);
        checkVal("ramp_first_din", firstDin, 32'h0003_0002);

        // decim=2, num_words=2: words {s3,s0} and {s9,s6}, s0 arriving at idx 2.
        strobes = 0; firstDin = '0; secondDin = '0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(i == 0, 1'b0, 24'd2, 8'd2, 16'(i), 1'b0);
            if (fifo_wr_en) begin
                if (strobes == 1) firstDin = fifo_din; else secondDin = fifo_din;
            end
        end
        checkVal("dec_strobes", 32'(strobes), 32'd2);
        checkVal("dec_word0", firstDin, 32'h0005_0002);
        checkVal("dec_word1", secondDin, 32'h000B_0008);

        // Full FIFO during the second of three words.
        strobes = 0;
        for (int i = 0; i < 12; i++)
            applyStimulus(i == 0, 1'b0, 24'd3, 8'd0, 16'(i + 100), (i == 4 || i == 5));
        checkVal("full_strobes", 32'(strobes), 32'd2);
        checkVal("full_ovf", {31'd0, overflow}, 32'd1);
        checkVal("full_done", {31'd0, done}, 32'd1);

        // Continuous mode stopped by abort after 10 words, then a restart.
        strobes = 0;
        applyStimulus(1'b1, 1'b0, 24'd0, 8'd0, 16'h0, 1'b0);
        for (int i = 0; i < 100 && strobes < 10; i++)
            applyStimulus(1'b0, 1'b0, 24'd0, 8'd0, 16'(i), 1'b0);
        applyStimulus(1'b0, 1'b1, 24'd0, 8'd0, 16'h0, 1'b0);
        checkVal("cont_strobes", 32'(strobes), 32'd10);
        checkVal("cont_busy", {31'd0, busy}, 32'd0);
        checkVal("cont_done", {31'd0, done}, 32'd0);
        applyStimulus(1'b1, 1'b0, 24'd1, 8'd0, 16'h0, 1'b0);
        checkVal("restart_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 24'd1, 8'd0, 16'(i), 1'b0);
        checkVal("restart_done", {31'd0, done}, 32'd1);
`else
        // Trigger: ch1 10,20,31,32 enters CAPTURE on the 32 edge; next samples form the word.
        strobes = 0; firstDin = '0;
        applyStimulus(1'b1, 1'b0, 24'd1, 8'd0, 16'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 24'd1, 8'd0, {6'd10, 10'd0}, 1'b0);
        applyStimulus(1'b0, 1'b0, 24'd1, 8'd0, {6'd20, 10'd0}, 1'b0);
        applyStimulus(1'b0, 1'b0, 24'd1, 8'd0, {6'd31, 10'd0}, 1'b0);
        applyStimulus(1'b0, 1'b0, 24'd1, 8'd0, {6'd32, 10'd0}, 1'b0);
        applyStimulus(1'b0, 1'b0, 24'd1, 8'd0, 16'h1234, 1'b0);
        checkVal("trig_no_early", 32'(strobes), 32'd0);
        applyStimulus(1'b0, 1'b0, 24'd1, 8'd0, 16'h5678, 1'b0);
        checkVal("trig_strobe", {31'd0, fifo_wr_en}, 32'd1);
        checkVal("trig_din", fifo_din, 32'h5678_1234);
        checkVal("trig_done", {31'd0, done}, 32'd1);
        // Steady level above threshold never triggers.
        strobes = 0;
        applyStimulus(1'b1, 1'b0, 24'd1, 8'd0, {6'd40, 10'd0}, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 24'd1, 8'd0, {6'd40, 10'd0}, 1'b0);
        checkVal("steady_strobes", 32'(strobes), 32'd0);
        checkVal("steady_busy", {31'd0, busy}, 32'd1);
        applyStimulus(1'b0, 1'b1, 24'd1, 8'd0, 16'h0, 1'b0);
        checkVal("steady_abort", {31'd0, busy}, 32'd0);
        trig_level = 6'd20;
`endif

        // Reset mid-capture clears all outputs immediately.
        applyStimulus(1'b1, 1'b0, 24'd0, 8'd0, 16'h0, 1'b0);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 1'b0, 24'd0, 8'd0, {6'(i * 12), 10'(i)}, 1'b0);
        #1;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAllZero("midreset");
        applyStimulus(1'b1, 1'b0, 24'd2, 8'd0, 16'h0, 1'b0);
        @(negedge dco);
        rst_n = 1'b1;

        // start and abort together in IDLE are ignored.
        applyStimulus(1'b1, 1'b1, 24'd2, 8'd0, 16'h0, 1'b0);
        checkVal("startabort_busy", {31'd0, busy}, 32'd0);
        applyStimulus(1'b0, 1'b0, 24'd2, 8'd0, 16'h0, 1'b0);
        checkAllZero("startabort");

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
`ifdef ADC_CAPTURE_TRIG_EN
            if (i % 500 == 0) trig_level = 6'($urandom_range(1, 63));
`endif
            applyStimulus(($urandom % 10) == 0, ($urandom % 50) == 0,
                          24'($urandom_range(0, 6)), 8'($urandom_range(0, 3)),
                          16'($urandom), ($urandom % 5) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
